// File: rtl/evo_test_pkg.sv
// Shared definitions for the evolved flip-flop test harness.
// FSM states, LFSR taps and default seed, and the synchroniser settle offset.
package evo_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   // x^16 + x^14 + x^13 + x^11 + 1, taken from bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
   localparam int unsigned SYNC_OFFSET       = 2;

endpackage

// File: rtl/evo_lfsr16.sv
// 16-bit Fibonacci LFSR, shift-left, with synchronous load (priority) and advance.
// Shared by the evolved-circuit testers.
module evo_lfsr16
   import evo_test_pkg::*;
#(
   parameter logic [15:0] RESET_VAL = LFSR_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_VAL;
      end else if (load) begin
         state <= seed;
      end else if (advance) begin
         state <= {state[14:0], ^(state & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/evo_ff_tester.sv
// Stimulus/response harness for an evolved D flip-flop: drives LFSR vectors, checks against a DFF model.
// Optional output-instability detection is enabled with `define EVO_OSC_DETECT_EN.
module evo_ff_tester
   import evo_test_pkg::*;
#(
   parameter int unsigned NUM_VECTORS   = 256,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT,
   parameter int unsigned ERR_W         = 16,
   parameter int unsigned IDX_W         = $clog2(NUM_VECTORS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [IDX_W-1:0] first_fail,
   output logic [ERR_W-1:0] osc_count,
   output logic [1:0]       dut_in,
   input  logic             dut_out
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);

   state_t             fsm, fsm_nxt;
   logic [15:0]        lfsr_state;
   logic [13:0]        lfsr_unused;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   cnt;
   logic               exp_q, exp_valid;
   logic               sync1, sync2;
   logic               accept, last_idx, vec_err, unstable_now, osc_ok_nxt;
   logic [ERR_W-1:0]   err_nxt;

   assign accept      = (fsm == ST_IDLE) && start;
   assign last_idx    = (idx == IDX_W'(NUM_VECTORS - 1));
   assign lfsr_unused = lfsr_state[15:2];

   evo_lfsr16 #(
      .RESET_VAL (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .seed    (LFSR_SEED),
      .advance (fsm == ST_APPLY),
      .state   (lfsr_state)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= dut_out;
         sync2 <= sync1;
      end
   end

`ifdef EVO_OSC_DETECT_EN
   // sync2 first shows the new response at settle count SYNC_OFFSET; only later changes are instability
   localparam logic [CNT_W-1:0] OSC_FROM = CNT_W'(SYNC_OFFSET + 1);

   logic             sync_prev, unstable_q;
   logic [ERR_W-1:0] osc_q, osc_nxt;

   assign unstable_now = unstable_q | (sync2 != sync_prev);
   assign osc_nxt      = (unstable_now && !(&osc_q)) ? osc_q + ERR_W'(1) : osc_q;
   assign osc_ok_nxt   = (osc_nxt == '0);
   assign osc_count    = osc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_prev  <= 1'b0;
         unstable_q <= 1'b0;
         osc_q      <= '0;
      end else begin
         sync_prev <= sync2;
         case (fsm)
            ST_IDLE:   if (start) osc_q <= '0;
            ST_APPLY:  unstable_q <= 1'b0;
            ST_SETTLE: if (cnt >= OSC_FROM && sync2 != sync_prev) unstable_q <= 1'b1;
            ST_SAMPLE: osc_q <= osc_nxt;
            default:   ;
         endcase
      end
   end
`else
   assign unstable_now = 1'b0;
   assign osc_ok_nxt   = 1'b1;
   assign osc_count    = '0;
`endif

   assign vec_err = unstable_now | (exp_valid & (sync2 != exp_q));
   assign err_nxt = (vec_err && !(&err_count)) ? err_count + ERR_W'(1) : err_count;

   always_comb begin
      fsm_nxt = fsm;
      busy    = 1'b0;
      done    = 1'b0;
      case (fsm)
         ST_IDLE:   if (start) fsm_nxt = ST_APPLY;
         ST_APPLY:  begin
            busy    = 1'b1;
            fsm_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            busy = 1'b1;
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) fsm_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            busy    = 1'b1;
            fsm_nxt = last_idx ? ST_DONE : ST_APPLY;
         end
         ST_DONE:   begin
            done    = 1'b1;
            fsm_nxt = ST_IDLE;
         end
         default:   fsm_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm <= ST_IDLE;
      else        fsm <= fsm_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_in     <= 2'b00;
         exp_q      <= 1'b0;
         exp_valid  <= 1'b0;
         idx        <= '0;
         cnt        <= '0;
         err_count  <= '0;
         first_fail <= '1;
         pass       <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (start) begin
                  exp_valid  <= 1'b0;
                  idx        <= '0;
                  err_count  <= '0;
                  first_fail <= '1;
                  pass       <= 1'b0;
               end
            end
            ST_APPLY: begin
               dut_in <= lfsr_state[1:0];
               cnt    <= '0;
               // reference DFF: capture D on a rising edge of the driven clock bit
               if (!dut_in[1] && lfsr_state[1]) begin
                  exp_q     <= lfsr_state[0];
                  exp_valid <= 1'b1;
               end
            end
            ST_SETTLE: cnt <= cnt + CNT_W'(1);
            ST_SAMPLE: begin
               err_count <= err_nxt;
               if (vec_err && err_count == '0) first_fail <= idx;
               idx <= idx + IDX_W'(1);
               if (last_idx) pass <= (err_nxt == '0) && osc_ok_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_evo_ff_tester.sv
// Directed bench for evo_ff_tester with a vector-level reference model and per-cycle compare.
module tb_evo_ff_tester;

   localparam int N       = 16;
   localparam int S       = 4;
   localparam int VLEN    = S + 2;
   localparam int RUN_LEN = N * VLEN + 1;
`ifdef EVO_OSC_DETECT_EN
   localparam bit OSC = 1'b1;
`else
   localparam bit OSC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   always #5 clk = ~clk;

   logic       busy0, done0, pass0, busy1, done1, pass1;
   logic [15:0] err0, osc0;
   logic [1:0]  err1, osc1;
   logic [3:0]  ff0, ff1;
   logic [1:0]  din0, din1;
   logic        dout0, dout1;

   evo_ff_tester #(.NUM_VECTORS(N), .SETTLE_CYCLES(S)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .first_fail(ff0), .osc_count(osc0), .dut_in(din0), .dut_out(dout0));

   evo_ff_tester #(.NUM_VECTORS(N), .SETTLE_CYCLES(S), .ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_fail(ff1), .osc_count(osc1), .dut_in(din1), .dut_out(dout1));

   // behavioural DUTs: ideal DFFs clocked by dut_in[1], plus a free-running toggler
   logic q0 = 1'b0, q1 = 1'b0, tog = 1'b0;
   logic dclk0, dclk1;
   int   mode = 0;
   assign dclk0 = din0[1];
   assign dclk1 = din1[1];
   always @(posedge dclk0) q0 <= din0[0];
   always @(posedge dclk1) q1 <= din1[0];
   always @(posedge clk) tog <= ~tog;
   assign dout0 = (mode == 0) ? q0 : (mode == 1) ? ~q0 : (mode == 2) ? 1'b0 : tog;
   assign dout1 = ~q1;

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model, evaluated per vector from the spec's rules
   logic [1:0] mvec [N];
   logic [1:0] prev_din_m = 2'b00, m_din_pre = 2'b00;
   int m_err, m_ff, m_osc, m_pass, m2_err, m2_ff, m2_pass, m_first_valid;
   bit m_chk_err;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic build_model(input int md);
      logic [15:0] s = 16'hACE1;
      logic pc, ev, eq, resp;
      bit unst, bad;
      int cnt = 0, ff = -1, vcnt = 0, vff = -1;
      m_din_pre = prev_din_m;
      pc = prev_din_m[1];
      ev = 1'b0;
      eq = 1'b0;
      for (int v = 0; v < N; v++) begin
         mvec[v] = s[1:0];
         if (!pc && s[1]) begin
            ev = 1'b1;
            eq = s[0];
         end
         pc = s[1];
         unst = (md == 3) && OSC;
         case (md)
            1:       resp = ~eq;
            2:       resp = 1'b0;
            default: resp = eq;
         endcase
         bad = unst || (ev && resp != eq);
         if (bad) begin
            cnt++;
            if (ff < 0) ff = v;
         end
         if (ev) begin
            vcnt++;
            if (vff < 0) vff = v;
         end
         s = lfsr_next(s);
      end
      prev_din_m    = mvec[N-1];
      m_err         = cnt;
      m_ff          = (ff < 0) ? 15 : ff;
      m_osc         = ((md == 3) && OSC) ? N : 0;
      m_pass        = (cnt == 0) ? 1 : 0;
      m_chk_err     = !((md == 3) && !OSC);
      m2_err        = (vcnt > 3) ? 3 : vcnt;
      m2_ff         = (vff < 0) ? 15 : vff;
      m2_pass       = (vcnt == 0) ? 1 : 0;
      m_first_valid = vff;
   endtask

   // per-cycle compare against the model's run timeline
   int t = 0;
   bit armed = 1'b0, go_req = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         armed = 1'b0;
      end else if (armed) begin
         int v;
         logic [1:0] exp_din;
         t++;
         v = (t - 2) / VLEN;
         exp_din = (t < 2) ? m_din_pre : mvec[v];
         check("busy",     int'(busy0), int'(t >= 1 && t < RUN_LEN));
         check("done",     int'(done0), int'(t == RUN_LEN));
         check("dut_in",   int'(din0),  int'(exp_din));
         check("busy_w2",  int'(busy1), int'(t >= 1 && t < RUN_LEN));
         check("done_w2",  int'(done1), int'(t == RUN_LEN));
         check("dut_in_w2", int'(din1), int'(exp_din));
         if (t == RUN_LEN) begin
            if (m_chk_err) begin
               check("err_count",  int'(err0), m_err);
               check("first_fail", int'(ff0),  m_ff);
               check("pass",       int'(pass0), m_pass);
            end
            check("osc_count",     int'(osc0), m_osc);
            check("err_count_w2",  int'(err1), m2_err);
            check("first_fail_w2", int'(ff1),  m2_ff);
            check("pass_w2",       int'(pass1), m2_pass);
            check("osc_count_w2",  int'(osc1), 0);
            armed = 1'b0;
         end
      end else if (go_req && start) begin
         armed  = 1'b1;
         go_req = 1'b0;
         t      = 0;
      end else begin
         check("idle_busy", int'(busy0), 0);
         check("idle_done", int'(done0), 0);
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_dut_in"},     int'(din0),  0);
      check({tag, "_busy"},       int'(busy0), 0);
      check({tag, "_done"},       int'(done0), 0);
      check({tag, "_pass"},       int'(pass0), 0);
      check({tag, "_err_count"},  int'(err0),  0);
      check({tag, "_osc_count"},  int'(osc0),  0);
      check({tag, "_first_fail"}, int'(ff0),   15);
   endtask

   task automatic do_run(input int md, input int pulse_at, input int abort_at);
      int n = 0;
      bit got = 1'b0;
      mode = md;
      build_model(md);
      @(posedge clk); #1;
      start  = 1'b1;
      go_req = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (n < 300 && !got) begin
         @(negedge clk);
         n++;
         if (done0) got = 1'b1;
         if (n == pulse_at) begin
            #1 start = 1'b1;
         end else if (n == pulse_at + 1) begin
            start = 1'b0;
         end
         if (n == abort_at) begin
            #2 rst_n = 1'b0;
            #1 check_reset_vals("abort");
            prev_din_m = 2'b00;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (12) @(negedge clk);
            return;
         end
      end
      check("run_len", n, 97);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      do_run(0, 0, 0);
      check("pin_vec0", int'(mvec[0]), 1);
      check("pin_vec1", int'(mvec[1]), 3);
      check("pin_vec4", int'(mvec[4]), 2);
      check("pin_first_valid", m_first_valid, 1);
      check("ideal_pass", int'(pass0), 1);
      check("ideal_err", int'(err0), 0);
      check("ideal_first_fail", int'(ff0), 15);
      check("w2_sat", int'(err1), 3);
      check("w2_first_fail", int'(ff1), 1);

      do_run(1, 0, 0);
      check("inv_pass", int'(pass0), 0);
      do_run(2, 0, 0);
      do_run(3, 0, 0);
      check("toggle_osc", int'(osc0), OSC ? 16 : 0);
      do_run(0, 0, 40);
      do_run(0, 0, 0);
      check("after_abort_pass", int'(pass0), 1);
      do_run(1, 30, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
